// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the iterative divider: operand width, iteration
//   counter width and the controller state encoding.
package div_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// div_step
//   One combinational restoring-division iteration.
//   rem      : partial remainder (W+1 bits)
//   quo      : shifting dividend/quotient register (W bits)
//   dvs      : divisor magnitude (W bits)
//   rem_next : partial remainder after the step
//   quo_next : quotient register after the step (new bit in LSB)
module div_step
    import div_pkg::*;
(
    input  logic [W:0]   rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] dvs,
    output logic [W:0]   rem_next,
    output logic [W-1:0] quo_next
);

    // One extra bit above the W+1-bit remainder so the trial-subtract
    // borrow is visible even when the shifted remainder exceeds 2^W.
    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = shifted - {2'b00, dvs};
        if (diff[W+1]) begin
            rem_next = shifted[W:0];
            quo_next = {quo[W-2:0], 1'b0};
        end else begin
            rem_next = diff[W:0];
            quo_next = {quo[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit
//   Iterative 32-bit DIV/DIVU unit feeding the HI/LO register-file port.
//   clk, resetn          : clock, async active-low reset
//   start, signed_op     : request (sampled in IDLE), 1 = signed DIV
//   dividend, divisor    : operands, captured with start
//   cancel               : pipeline flush, aborts any operation
//   stall_req, busy      : pipeline hold / unit occupied
//   result_valid         : one-cycle pulse, mirrored on hi_we and lo_we
//   hi_wdata, lo_wdata   : remainder / quotient, registered
module div_unit
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         cancel,
    output logic         stall_req,
    output logic         busy,
    output logic         result_valid,
    output logic         hi_we,
    output logic         lo_we,
    output logic [W-1:0] hi_wdata,
    output logic [W-1:0] lo_wdata
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     dvd_r;
    logic [W-1:0]     dvs_r;
    logic             sop_r;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [W-1:0]     dvs_mag;
    logic [W:0]       rem;
    logic [W-1:0]     quo;
    logic [W:0]       rem_nx;
    logic [W-1:0]     quo_nx;

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs_mag),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            dvd_r        <= '0;
            dvs_r        <= '0;
            sop_r        <= 1'b0;
            dvd_neg      <= 1'b0;
            dvs_neg      <= 1'b0;
            dvs_mag      <= '0;
            rem          <= '0;
            quo          <= '0;
            result_valid <= 1'b0;
            hi_wdata     <= '0;
            lo_wdata     <= '0;
        end else begin
            result_valid <= 1'b0;
            if (cancel && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !cancel) begin
                            dvd_r   <= dividend;
                            dvs_r   <= divisor;
                            sop_r   <= signed_op;
                            dvd_neg <= dividend[W-1];
                            dvs_neg <= divisor[W-1];
                            state   <= PREP;
                        end
                    end
                    PREP: begin
                        quo     <= (sop_r && dvd_neg) ? -dvd_r : dvd_r;
                        dvs_mag <= (sop_r && dvs_neg) ? -dvs_r : dvs_r;
                        rem     <= '0;
                        cnt     <= '0;
                        if (dvs_r == '0) begin
                            lo_wdata     <= '1;
                            hi_wdata     <= dvd_r;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(W - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        lo_wdata     <= (sop_r && (dvd_neg ^ dvs_neg)) ? -quo : quo;
                        hi_wdata     <= (sop_r && dvd_neg) ? -rem[W-1:0] : rem[W-1:0];
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // The IDLE term lets the pipeline freeze in the same cycle the request is accepted.
    assign stall_req = ((state == IDLE) && start && !cancel) ||
                       (state == PREP) || (state == CALC) || (state == FIX);
    assign busy      = (state != IDLE);
    assign hi_we     = result_valid;
    assign lo_we     = result_valid;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit
//   Self-checking bench for div_unit: scoreboard of expected HI/LO results,
//   latency/stall checks, cancel, divide-by-zero and mid-operation reset.
module tb_div_unit;
    import div_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         cancel;
    logic         stall_req;
    logic         busy;
    logic         result_valid;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] hi_wdata;
    logic [W-1:0] lo_wdata;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } res_t;

    res_t         exp_q[$];
    int unsigned  n_pass = 0;
    int unsigned  n_total = 0;
    int unsigned  pulse_cnt = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    div_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .signed_op    (signed_op),
        .dividend     (dividend),
        .divisor      (divisor),
        .cancel       (cancel),
        .stall_req    (stall_req),
        .busy         (busy),
        .result_valid (result_valid),
        .hi_we        (hi_we),
        .lo_we        (lo_we),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata)
    );

    always #5 clk = ~clk;

    // Pre-edge value: counts the cycles in which the write pulse was high.
    always @(posedge clk) begin
        if (result_valid === 1'b1 || hi_we === 1'b1 || lo_we === 1'b1) begin
            pulse_cnt++;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else if (!sop) begin
            r.lo = a / b;
            r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000;
            r.hi = 32'd0;
        end else begin
            r.lo = sa / sb;
            r.hi = sa % sb;
        end
        return r;
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in the IDLE cycle after DONE.
    task automatic do_op(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned lat);
        int unsigned n;
        logic        got;
        logic        hold_bad;
        res_t        e;
        exp_q.push_back(model(sop, a, b));
        start     = 1'b1;
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        #1;
        check("stall_cycle0", 32'(stall_req), 32'd1);
        n        = 0;
        got      = 1'b0;
        hold_bad = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            if (result_valid === 1'b1) begin
                got = 1'b1;
            end else if (stall_req !== 1'b1 || busy !== 1'b1) begin
                hold_bad = 1'b1;
            end
        end
        if (!got) begin
            check("result_timeout", 32'd0, 32'd1);
        end else begin
            check("stall_busy_hold", 32'(hold_bad), 32'd0);
            check("latency", n, lat);
            check("stall_in_done", 32'(stall_req), 32'd0);
            check("busy_in_done", 32'(busy), 32'd1);
            check("hi_lo_we", 32'({hi_we, lo_we}), 32'd3);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("lo_wdata", lo_wdata, e.lo);
                check("hi_wdata", hi_wdata, e.hi);
                last_lo = e.lo;
                last_hi = e.hi;
            end
            @(posedge clk);
            @(negedge clk);
            check("pulse_one_cycle", 32'({result_valid, hi_we, lo_we}), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int unsigned p0;
        resetn    = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        cancel    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_we", 32'({result_valid, hi_we, lo_we}), 32'd0);
        check("rst_hi", hi_wdata, 32'd0);
        check("rst_lo", lo_wdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        do_op(1'b0, 32'd100, 32'd7, 35);
        do_op(1'b1, -32'd7, 32'd2, 35);
        do_op(1'b1, 32'd7, -32'd2, 35);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 35);
        do_op(1'b0, 32'd5, 32'd0, 2);
        do_op(1'b1, -32'd9, 32'd0, 2);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        do_op(1'b1, -32'd100, -32'd7, 35);
        do_op(1'b1, -32'd6, 32'd3, 35);
        for (int i = 0; i < 6; i++) begin
            do_op(1'(i % 2), $urandom, 32'($urandom_range(1, 32'hFFFF_FFFF)), 35);
        end

        // Cancel in cycle 10 of an operation.
        p0        = pulse_cnt;
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_idle", 32'(busy), 32'd0);
        check("cancel_stall", 32'(stall_req), 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_no_pulse", pulse_cnt - p0, 32'd0);
        check("cancel_hi_kept", hi_wdata, last_hi);
        check("cancel_lo_kept", lo_wdata, last_lo);
        do_op(1'b1, -32'd1000, 32'd3, 35);

        // cancel together with start in IDLE.
        start    = 1'b1;
        cancel   = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        #1;
        check("cancel_start_stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("cancel_start_busy2", 32'(busy), 32'd0);

        // Reset in cycle 20 of an operation.
        p0        = pulse_cnt;
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd17;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_we", 32'({result_valid, hi_we, lo_we}), 32'd0);
        check("midrst_hi", hi_wdata, 32'd0);
        check("midrst_lo", lo_wdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_pulse", pulse_cnt - p0, 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        do_op(1'b0, 32'd12345, 32'd17, 35);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
